// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
//
// Shared definitions for the data-side memory bus arbiter:
//   - bus width constants (address, data, byte-lane mask)
//   - region decode: one address bit selects boot-ROM port 2 or data RAM
//   - owner encoding for the two masters
//   - the registered response record carried from grant to response cycle
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

   localparam int BUS_ADDR_W  = 10;
   localparam int BUS_DATA_W  = 32;
   localparam int BUS_WIDTH_W = 4;

   // Address bit that splits the data map into ROM (low half) and RAM (high half).
   localparam int REGION_BIT  = 9;

   // Lock counter is wide enough for the largest legal LOCK_MAX (15).
   localparam int LOCK_CNT_W  = 4;

   typedef enum logic {
      REGION_ROM = 1'b0,
      REGION_RAM = 1'b1
   } region_e;

   typedef enum logic {
      OWNER_M0 = 1'b0,
      OWNER_M1 = 1'b1
   } owner_e;

   // Everything the response cycle needs to know about the transfer granted
   // in the previous cycle.
   typedef struct packed {
      logic    valid;
      owner_e  owner;
      region_e region;
      logic    write;
      logic    rom_write_err;
   } resp_t;

   // Decode the region select bit of an address.
   function automatic region_e addr_region(input logic region_bit);
      return region_bit ? REGION_RAM : REGION_ROM;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb.sv
// -----------------------------------------------------------------------------
// rr_lock_arbiter2
//
// Two-requester round-robin arbiter with a bounded lock for requester 1.
// Grant is combinational from the requests and the registered state
// (last_owner, lock_cnt), so a request is granted in the cycle it appears.
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   req0, req1 - requests from master 0 / master 1
//   lock1      - master 1 asks to keep ownership back-to-back
//   gnt[1:0]   - one-hot grant (bit n = master n), all zero when idle
// -----------------------------------------------------------------------------
module rr_lock_arbiter2
   import mem_bus_arbiter_pkg::*;
#(
   parameter int LOCK_MAX = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic       req1,
   input  logic       lock1,
   output logic [1:0] gnt
);

   localparam logic [LOCK_CNT_W-1:0] LOCK_LIMIT = LOCK_CNT_W'(LOCK_MAX);

   owner_e                last_owner_q, last_owner_d;
   logic [LOCK_CNT_W-1:0] lock_cnt_q,   lock_cnt_d;
   logic                  lock_active;

   // A lock can only extend an ownership m1 already holds, and only until
   // LOCK_MAX grants have been taken from a waiting m0.
   assign lock_active = (last_owner_q == OWNER_M1) && req1 && lock1 &&
                        (lock_cnt_q < LOCK_LIMIT);

   always_comb begin
      gnt = 2'b00;
      if (lock_active) begin
         gnt = 2'b10;
      end else if (req0 && req1) begin
         // Tie: the master that did not own the bus last time wins.
         gnt = (last_owner_q == OWNER_M1) ? 2'b01 : 2'b10;
      end else if (req0) begin
         gnt = 2'b01;
      end else if (req1) begin
         gnt = 2'b10;
      end
   end

   always_comb begin
      last_owner_d = last_owner_q;
      if (gnt[0]) begin
         last_owner_d = OWNER_M0;
      end else if (gnt[1]) begin
         last_owner_d = OWNER_M1;
      end
   end

   // The counter measures how long m0 has been starved by a lock; it is only
   // meaningful while m0 waits and m1 keeps its lock asserted.
   always_comb begin
      lock_cnt_d = lock_cnt_q;
      if (gnt[0] || !lock1 || !req0) begin
         lock_cnt_d = '0;
      end else if (gnt[1]) begin
         lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_owner_q <= OWNER_M1;
         lock_cnt_q   <= '0;
      end else begin
         last_owner_q <= last_owner_d;
         lock_cnt_q   <= lock_cnt_d;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the boot-ROM second read port and the data RAM between two masters
// (m0 = CPU data port, m1 = loader / debug port). Address bit 9 selects the
// region (0 = ROM, 1 = RAM). One transfer per cycle; each granted transfer
// gets a single-cycle rvalid pulse one cycle after its grant.
//
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   mN_req/write/addr/wdata/width
//                            - master N request and its fields (held until gnt)
//   mN_gnt                   - combinational grant, transfer accepted this cycle
//   mN_rvalid/rdata/err      - response: pulse, read data, ROM-write error
//   m1_lock                  - m1 asks for back-to-back ownership
//   s_addr/wdata/width/write - shared slave drive to ROM port 2 and RAM
//   rom_rdata, ram_rdata     - memory read data, one cycle after s_addr
// -----------------------------------------------------------------------------
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W   = BUS_ADDR_W,
   parameter int DATA_W   = BUS_DATA_W,
   parameter int LOCK_MAX = 4
) (
   input  logic                   clk,
   input  logic                   rst,

   input  logic                   m0_req,
   input  logic                   m0_write,
   input  logic [ADDR_W-1:0]      m0_addr,
   input  logic [DATA_W-1:0]      m0_wdata,
   input  logic [BUS_WIDTH_W-1:0] m0_width,
   output logic                   m0_gnt,
   output logic                   m0_rvalid,
   output logic [DATA_W-1:0]      m0_rdata,
   output logic                   m0_err,

   input  logic                   m1_req,
   input  logic                   m1_write,
   input  logic [ADDR_W-1:0]      m1_addr,
   input  logic [DATA_W-1:0]      m1_wdata,
   input  logic [BUS_WIDTH_W-1:0] m1_width,
   input  logic                   m1_lock,
   output logic                   m1_gnt,
   output logic                   m1_rvalid,
   output logic [DATA_W-1:0]      m1_rdata,
   output logic                   m1_err,

   output logic [ADDR_W-1:0]      s_addr,
   output logic [DATA_W-1:0]      s_wdata,
   output logic [BUS_WIDTH_W-1:0] s_width,
   output logic                   s_write,
   input  logic [DATA_W-1:0]      rom_rdata,
   input  logic [DATA_W-1:0]      ram_rdata
);

   logic [1:0]             gnt;
   logic                   any_gnt;

   logic                   sel_write;
   logic [ADDR_W-1:0]      sel_addr;
   logic [DATA_W-1:0]      sel_wdata;
   logic [BUS_WIDTH_W-1:0] sel_width;
   region_e                sel_region;

   logic [ADDR_W-1:0]      s_addr_q,  s_addr_d;
   logic [DATA_W-1:0]      s_wdata_q, s_wdata_d;
   logic [BUS_WIDTH_W-1:0] s_width_q, s_width_d;

   resp_t                  resp_q, resp_d;
   logic [DATA_W-1:0]      resp_rdata;
   logic [1:0]             rvalid_vec;
   logic [1:0]             err_vec;
   logic [DATA_W-1:0]      rdata_vec [2];

   // ---------------------------------------------------------------- arbiter
   rr_lock_arbiter2 #(
      .LOCK_MAX (LOCK_MAX)
   ) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req0  (m0_req),
      .req1  (m1_req),
      .lock1 (m1_lock),
      .gnt   (gnt)
   );

   assign any_gnt = |gnt;
   assign m0_gnt  = gnt[0];
   assign m1_gnt  = gnt[1];

   // ------------------------------------------------------------ request mux
   always_comb begin
      sel_write = m0_write;
      sel_addr  = m0_addr;
      sel_wdata = m0_wdata;
      sel_width = m0_width;
      if (gnt[1]) begin
         sel_write = m1_write;
         sel_addr  = m1_addr;
         sel_wdata = m1_wdata;
         sel_width = m1_width;
      end
   end

   assign sel_region = addr_region(sel_addr[REGION_BIT]);

   // Slave fields follow the granted master in the grant cycle and otherwise
   // hold the last granted value, so the memory address lines stay quiet.
   always_comb begin
      s_addr_d  = s_addr_q;
      s_wdata_d = s_wdata_q;
      s_width_d = s_width_q;
      if (any_gnt) begin
         s_addr_d  = sel_addr;
         s_wdata_d = sel_wdata;
         s_width_d = sel_width;
      end
   end

   assign s_addr  = s_addr_d;
   assign s_wdata = s_wdata_d;
   assign s_width = s_width_d;

   // ROM has no write path; writes into ROM space are dropped here and
   // reported back as an error instead.
   assign s_write = any_gnt && sel_write && (sel_region == REGION_RAM);

   // ------------------------------------------------------ response pipeline
   always_comb begin
      resp_d               = '0;
      resp_d.valid         = any_gnt;
      resp_d.owner         = gnt[1] ? OWNER_M1 : OWNER_M0;
      resp_d.region        = sel_region;
      resp_d.write         = sel_write;
      resp_d.rom_write_err = any_gnt && sel_write && (sel_region == REGION_ROM);
   end

   // Both memories have one cycle of read latency, so their outputs line up
   // with the registered response record.
   always_comb begin
      resp_rdata = '0;
      if (!resp_q.write) begin
         resp_rdata = (resp_q.region == REGION_RAM) ? ram_rdata : rom_rdata;
      end
   end

   // Route the response to its owner; the other master sees all zeros.
   for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      assign rvalid_vec[gi] = resp_q.valid &&
                              (resp_q.owner == ((gi == 1) ? OWNER_M1 : OWNER_M0));
      assign err_vec[gi]    = rvalid_vec[gi] && resp_q.rom_write_err;
      assign rdata_vec[gi]  = rvalid_vec[gi] ? resp_rdata : '0;
   end

   assign m0_rvalid = rvalid_vec[0];
   assign m0_err    = err_vec[0];
   assign m0_rdata  = rdata_vec[0];
   assign m1_rvalid = rvalid_vec[1];
   assign m1_err    = err_vec[1];
   assign m1_rdata  = rdata_vec[1];

   // -------------------------------------------------------------- registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_addr_q  <= '0;
         s_wdata_q <= '0;
         s_width_q <= '0;
         resp_q    <= '0;
      end else begin
         s_addr_q  <= s_addr_d;
         s_wdata_q <= s_wdata_d;
         s_width_q <= s_width_d;
         resp_q    <= resp_d;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;

   logic          m0_req = 0, m0_write = 0;
   logic [AW-1:0] m0_addr = '0;
   logic [DW-1:0] m0_wdata = '0;
   logic [3:0]    m0_width = 4'hF;
   logic          m0_gnt, m0_rvalid, m0_err;
   logic [DW-1:0] m0_rdata;

   logic          m1_req = 0, m1_write = 0, m1_lock = 0;
   logic [AW-1:0] m1_addr = '0;
   logic [DW-1:0] m1_wdata = '0;
   logic [3:0]    m1_width = 4'h3;
   logic          m1_gnt, m1_rvalid, m1_err;
   logic [DW-1:0] m1_rdata;

   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_wdata;
   logic [3:0]    s_width;
   logic          s_write;
   logic [DW-1:0] rom_rdata = '0;
   logic [DW-1:0] ram_rdata = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_width(m0_width), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m0_err(m0_err),
      .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_width(m1_width), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
      .m1_rdata(m1_rdata), .m1_err(m1_err),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_width(s_width), .s_write(s_write),
      .rom_rdata(rom_rdata), .ram_rdata(ram_rdata)
   );

   // Memory models: ROM word i = C0DE_00ii, RAM word i = A000_00ii initially.
   logic [DW-1:0] rom_mem [128];
   logic [DW-1:0] ram_mem [128];

   initial begin
      for (int i = 0; i < 128; i++) begin
         rom_mem[i] = 32'hC0DE_0000 | i;
         ram_mem[i] = 32'hA000_0000 | i;
      end
   end

   always @(posedge clk) begin
      logic [DW-1:0] merged;
      merged = ram_mem[s_addr[8:2]];
      for (int b = 0; b < 4; b++)
         if (s_width[b]) merged[8*b +: 8] = s_wdata[8*b +: 8];
      if (s_write) ram_mem[s_addr[8:2]] <= merged;
      ram_rdata <= ram_mem[s_addr[8:2]];
      rom_rdata <= rom_mem[s_addr[8:2]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      string         name;
      logic          m0r, m0w;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      logic          m1r, m1w, m1l;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      logic [1:0]    eg;    // expected {m1_gnt, m0_gnt}
      logic          esw;   // expected s_write
      logic [AW-1:0] esa;   // expected s_addr
      logic [1:0]    erv;   // expected {m1_rvalid, m0_rvalid}
      logic [DW-1:0] erd;   // expected rdata on the master with rvalid
      logic [1:0]    eerr;  // expected {m1_err, m0_err}
   } vec_t;

   function automatic vec_t mk(input string name,
         input logic m0r, input logic m0w, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
         input logic m1r, input logic m1w, input logic m1l, input logic [AW-1:0] a1,
         input logic [DW-1:0] d1, input logic [1:0] eg, input logic esw,
         input logic [AW-1:0] esa, input logic [1:0] erv, input logic [DW-1:0] erd,
         input logic [1:0] eerr);
      vec_t v;
      v.name = name; v.m0r = m0r; v.m0w = m0w; v.a0 = a0; v.d0 = d0;
      v.m1r = m1r; v.m1w = m1w; v.m1l = m1l; v.a1 = a1; v.d1 = d1;
      v.eg = eg; v.esw = esw; v.esa = esa; v.erv = erv; v.erd = erd; v.eerr = eerr;
      return v;
   endfunction

   localparam int NV = 26;
   vec_t vecs [NV];

   initial begin
      logic [DW-1:0] exp_wd;
      logic [3:0]    exp_wm;

      // Cycle-by-cycle table starting right after reset (last_owner = m1).
      for (int i = 0; i < 5; i++)
         vecs[i] = mk("idle", 0,0,10'h000,0, 0,0,0,10'h000,0, 2'b00,0,10'h000, 2'b00,0,2'b00);
      vecs[5]  = mk("tie_a",      1,0,10'h1FF,0, 1,0,0,10'h200,0, 2'b01,0,10'h1FF, 2'b00,32'h0,2'b00);
      vecs[6]  = mk("tie_b",      1,0,10'h1FF,0, 1,0,0,10'h200,0, 2'b10,0,10'h200, 2'b01,32'hC0DE007F,2'b00);
      vecs[7]  = mk("tie_c",      1,0,10'h1FF,0, 1,0,0,10'h200,0, 2'b01,0,10'h1FF, 2'b10,32'hA0000000,2'b00);
      vecs[8]  = mk("tie_drain",  0,0,10'h000,0, 0,0,0,10'h000,0, 2'b00,0,10'h1FF, 2'b01,32'hC0DE007F,2'b00);
      vecs[9]  = mk("m0_ram_wr",  1,1,10'h204,32'hDEADBEEF, 0,0,0,10'h000,0, 2'b01,1,10'h204, 2'b00,0,2'b00);
      vecs[10] = mk("m0_ram_rd",  1,0,10'h204,0, 0,0,0,10'h000,0, 2'b01,0,10'h204, 2'b01,32'h0,2'b00);
      vecs[11] = mk("rd_drain",   0,0,10'h000,0, 0,0,0,10'h000,0, 2'b00,0,10'h204, 2'b01,32'hDEADBEEF,2'b00);
      vecs[12] = mk("m1_alone",   0,0,10'h000,0, 1,0,1,10'h210,0, 2'b10,0,10'h210, 2'b00,0,2'b00);
      for (int i = 13; i < 17; i++)
         vecs[i] = mk("lock_hold", 1,0,10'h010,0, 1,0,1,10'h210,0, 2'b10,0,10'h210, 2'b10,32'hA0000004,2'b00);
      vecs[17] = mk("lock_rel",   1,0,10'h010,0, 1,0,1,10'h210,0, 2'b01,0,10'h010, 2'b10,32'hA0000004,2'b00);
      vecs[18] = mk("m1_rom_wr",  0,0,10'h000,0, 1,1,0,10'h010,32'h12345678, 2'b10,0,10'h010, 2'b01,32'hC0DE0004,2'b00);
      vecs[19] = mk("m1_rom_rd",  0,0,10'h000,0, 1,0,0,10'h010,0, 2'b10,0,10'h010, 2'b10,32'h0,2'b10);
      vecs[20] = mk("rom_drain",  0,0,10'h000,0, 0,0,0,10'h000,0, 2'b00,0,10'h010, 2'b10,32'hC0DE0004,2'b00);
      vecs[21] = mk("bnd_1ff_wr", 1,1,10'h1FF,32'h55AA55AA, 0,0,0,10'h000,0, 2'b01,0,10'h1FF, 2'b00,0,2'b00);
      vecs[22] = mk("bnd_200_wr", 1,1,10'h200,32'h55AA55AA, 0,0,0,10'h000,0, 2'b01,1,10'h200, 2'b01,32'h0,2'b01);
      vecs[23] = mk("bnd_drain",  0,0,10'h000,0, 0,0,0,10'h000,0, 2'b00,0,10'h200, 2'b01,32'h0,2'b00);
      vecs[24] = mk("bnd_200_rd", 1,0,10'h200,0, 0,0,0,10'h000,0, 2'b01,0,10'h200, 2'b00,0,2'b00);
      vecs[25] = mk("bnd_drain2", 0,0,10'h000,0, 0,0,0,10'h000,0, 2'b00,0,10'h200, 2'b01,32'h55AA55AA,2'b00);

      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_gnt",    {30'd0, m1_gnt, m0_gnt}, 32'd0);
      chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
      chk("rst_err",    {30'd0, m1_err, m0_err}, 32'd0);
      chk("rst_rdata0", m0_rdata, 32'd0);
      chk("rst_rdata1", m1_rdata, 32'd0);
      chk("rst_s_addr", {22'd0, s_addr}, 32'd0);
      chk("rst_s_write", {31'd0, s_write}, 32'd0);
      chk("rst_s_wdata", s_wdata, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         @(posedge clk); #1;
         m0_req = vecs[i].m0r; m0_write = vecs[i].m0w; m0_addr = vecs[i].a0; m0_wdata = vecs[i].d0;
         m1_req = vecs[i].m1r; m1_write = vecs[i].m1w; m1_lock = vecs[i].m1l;
         m1_addr = vecs[i].a1; m1_wdata = vecs[i].d1;
         @(negedge clk);
         chk({vecs[i].name, "_gnt"},     {30'd0, m1_gnt, m0_gnt}, {30'd0, vecs[i].eg});
         chk({vecs[i].name, "_s_write"}, {31'd0, s_write}, {31'd0, vecs[i].esw});
         chk({vecs[i].name, "_s_addr"},  {22'd0, s_addr}, {22'd0, vecs[i].esa});
         chk({vecs[i].name, "_rvalid"},  {30'd0, m1_rvalid, m0_rvalid}, {30'd0, vecs[i].erv});
         chk({vecs[i].name, "_err"},     {30'd0, m1_err, m0_err}, {30'd0, vecs[i].eerr});
         chk({vecs[i].name, "_rdata0"},  m0_rdata, vecs[i].erv[0] ? vecs[i].erd : 32'd0);
         chk({vecs[i].name, "_rdata1"},  m1_rdata, vecs[i].erv[1] ? vecs[i].erd : 32'd0);
         if (vecs[i].eg != 2'b00) begin
            exp_wd = vecs[i].eg[1] ? vecs[i].d1 : vecs[i].d0;
            exp_wm = vecs[i].eg[1] ? 4'h3 : 4'hF;
            chk({vecs[i].name, "_s_wdata"}, s_wdata, exp_wd);
            chk({vecs[i].name, "_s_width"}, {28'd0, s_width}, {28'd0, exp_wm});
         end
         $display("vec %0d %s: gnt=%b%b rvalid=%b%b err=%b%b s_write=%b s_addr=0x%03h rdata0=0x%08h rdata1=0x%08h",
                  i, vecs[i].name, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, m1_err, m0_err,
                  s_write, s_addr, m0_rdata, m1_rdata);
      end

      // Reset mid-operation: in-flight response is dropped, last_owner restored.
      @(posedge clk); #1;
      m0_req = 1; m0_write = 0; m0_addr = 10'h204;
      m1_req = 0; m1_write = 0; m1_lock = 0;
      @(negedge clk);
      chk("midrst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
      $display("midrst grant: gnt=%b%b", m1_gnt, m0_gnt);
      @(posedge clk); #1;
      m0_req = 0;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
      chk("midrst_rdata0", m0_rdata, 32'd0);
      $display("midrst in reset: rvalid=%b%b", m1_rvalid, m0_rvalid);
      rst = 1'b0;
      @(posedge clk); #1;
      m0_req = 1; m0_addr = 10'h010;
      m1_req = 1; m1_addr = 10'h210;
      @(negedge clk);
      chk("midrst_tie_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
      chk("midrst_tie_s_addr", {22'd0, s_addr}, 32'h010);
      $display("post-reset tie: gnt=%b%b s_addr=0x%03h", m1_gnt, m0_gnt, s_addr);
      @(posedge clk); #1;
      m0_req = 0; m1_req = 0;
      @(negedge clk);
      chk("midrst_tie_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd1);
      chk("midrst_tie_rdata", m0_rdata, 32'hC0DE0004);
      $display("post-reset tie response: rvalid=%b%b rdata0=0x%08h", m1_rvalid, m0_rvalid, m0_rdata);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, one-slave-port arbiter for the data-side memory bus.
- Master 0 is the CPU data port. Master 1 is a secondary requester, such as a program loader or debug port.
- Shares the boot-ROM second read port and the data RAM between the two masters, decodes address bit 9 (0 = ROM, 1 = RAM), and returns registered responses.
- Round-robin arbitration. Master 1 can lock the bus for a bounded burst.

Parameters:
- ADDR_W, 10, byte address width of the data bus
- DATA_W, 32, data width
- LOCK_MAX, 4, max consecutive locked grants to m1 while m0 is waiting; range 1..15

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- m0_req  in  1  CPU transfer request; held with its fields until m0_gnt
- m0_write  in  1  1 = write, 0 = read
- m0_addr  in  ADDR_W  byte address
- m0_wdata  in  DATA_W  write data
- m0_width  in  4  byte-lane mask, passed through
- m0_gnt  out  1  combinational grant; the transfer is accepted this cycle
- m0_rvalid  out  1  one-cycle response pulse, one cycle after grant
- m0_rdata  out  DATA_W  read data, valid with m0_rvalid on reads
- m0_err  out  1  with m0_rvalid: a write was attempted to ROM space
- m1_req, m1_write, m1_addr, m1_wdata, m1_width, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as m0
- m1_lock  in  1  m1 requests back-to-back ownership
- s_addr  out  ADDR_W  to ROM port 2 and RAM
- s_wdata  out  DATA_W  RAM write data
- s_width  out  4  RAM byte mask
- s_write  out  1  RAM write strobe
- rom_rdata  in  DATA_W  ROM port-2 data; synchronous, 1-cycle latency
- ram_rdata  in  DATA_W  RAM data; synchronous, 1-cycle latency

Behaviour:
- Reset values:
  - All gnt, rvalid and err outputs: 0.
  - rdata outputs and s_* outputs: 0.
  - Internal last_owner = 1, so m0 wins the first tie.
  - lock_cnt = 0; resp_pending = 0.
- Arbitration (combinational, from registered state):
  - Only one requester: that master is granted.
  - Both request, no active lock: grant goes to the master that is not last_owner.
  - Active lock is (last_owner = 1) AND m1_req AND m1_lock AND lock_cnt < LOCK_MAX. While active, m1 is granted even if m0 requests.
- lock_cnt:
  - Increments on each m1 grant made while m0_req = 1 and m1_lock = 1.
  - Clears on any m0 grant, and on any cycle where m1_lock = 0 or m0_req = 0.
  - At LOCK_MAX the lock is ignored, so m0 gets the next grant.
  - Maximum m0 wait is LOCK_MAX cycles.
- Slave drive:
  - s_addr, s_wdata and s_width mux the granted master's fields. With no grant they hold their previous value.
  - s_write = grant AND write AND addr[9].
  - Writes to ROM space (addr[9] = 0) are never forwarded.
- Response pipeline:
  - On grant, register owner, addr[9], write, and rom_write_err = write AND NOT addr[9].
  - Next cycle, pulse that owner's rvalid for exactly 1 cycle, for both reads and writes.
  - rdata = addr[9] ? ram_rdata : rom_rdata for reads. Writes return 0.
  - err = rom_write_err.
  - The non-owner's rvalid, rdata and err are 0.
- Throughput: one transfer per cycle. Back-to-back grants pipeline, so the response to transfer N coincides with the grant of transfer N+1.
- Response independence: a new grant in the cycle a response is presented is legal.
- Address boundary: addr 0x1FF decodes to ROM; addr 0x200 decodes to RAM. Lower address bits pass through unchanged, with no alignment check.
- Reset mid-operation: an asynchronous rst assertion drops any in-flight response (no rvalid). last_owner and lock_cnt return to their reset values.

Decomposition:
- Shared package holds:
  - bus width constants: ADDR_W, DATA_W, width-mask width 4
  - region decode constants: REGION_BIT = 9, REGION_ROM = 0, REGION_RAM = 1
  - owner encoding: OWNER_M0 = 0, OWNER_M1 = 1
- One natural sub-module, rr_lock_arbiter2: two requests plus lock in, one-hot grant out, owning last_owner and lock_cnt.
- Muxing and the response pipeline stay in mem_bus_arbiter.

Test Plan:
- Reset, then idle: after rst release with no requests, all gnt, rvalid and s_write stay 0 for 5 cycles.
- m0 RAM write then read:
  - m0 writes 0xDEADBEEF to 0x204, width 0xF → gnt that cycle; s_write = 1, s_addr = 0x204; m0_rvalid next cycle with err = 0.
  - m0 then reads 0x204 → m0_rvalid one cycle later with rdata = 0xDEADBEEF.
- Simultaneous requests from reset: both request reads for 3 cycles → grants go m0, m1, m0; each rvalid lands on the correct master one cycle after its grant.
- Lock bound, LOCK_MAX = 4: m1_lock = 1 and m1_req held, with m0_req asserted → m1 is granted 4 consecutive cycles, then m0 is granted on the 5th.
- ROM write rejected: m1 writes 0x12345678 to 0x010 → s_write = 0; m1_rvalid = 1 with m1_err = 1 next cycle; a later ROM read of 0x010 returns the original ROM contents.
- Reset mid-operation: assert rst in the cycle after an m0 read grant → no m0_rvalid. After release, a tie is granted to m0.
